// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory access controller.
// Loads are big-endian: the addressed byte sits in bits [31:24] of the returned word.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic {
        IDLE,
        MERGE
    } state_t;

    typedef enum logic {
        RSP_LOAD,
        RSP_STORE
    } rsp_kind_t;

    typedef struct packed {
        logic      pend;
        logic      port;
        rsp_kind_t kind;
        logic [1:0] size;
        logic      uns;
        logic      err;
    } rsp_t;

    function automatic logic [31:0] fmt_load(input logic [31:0] rd,
                                             input logic [1:0]  size,
                                             input logic        uns);
        logic [31:0] res;
        case (size)
            SZ_BYTE: res = uns ? {24'h000000, rd[31:24]} : {{24{rd[31]}}, rd[31:24]};
            SZ_HALF: res = uns ? {16'h0000, rd[31:16]}   : {{16{rd[31]}}, rd[31:16]};
            SZ_WORD: res = rd;
            default: res = rd;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin arbiter: the pointer-selected port wins ties and the
// pointer flips to the other port after every enabled grant.
module dmem_rr_arb (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_valid,
    input  logic       i_en,
    output logic [1:0] o_grant
);

    logic r_ptr;

    always_comb begin
        o_grant = '0;
        if (i_en) begin
            if (i_valid[r_ptr]) begin
                o_grant[r_ptr] = 1'b1;
            end else if (i_valid[~r_ptr]) begin
                o_grant[~r_ptr] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_en && (|o_grant)) begin
            r_ptr <= ~r_ptr;
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Shares the single-port big-endian data memory between the MEM stage (port 0)
// and the loader/debug port (port 1); subword stores are done by read-modify-write.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_BYTES = 5121
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0][1:0]        req_size,
    input  logic [1:0]             req_unsigned,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][31:0]       req_wdata,
    output logic [1:0]             rsp_valid,
    output logic                   rsp_err,
    output logic [31:0]            rsp_rdata,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic [31:0]            mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_OK = ADDR_W'(MEM_BYTES - 4);

    state_t r_state;
    state_t w_state_nx;

    logic [1:0]        w_grant;
    logic              w_en;
    logic              w_accept;
    logic              w_sel;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_size;
    logic              w_err;
    logic              w_sub;

    logic              r_m_port;
    logic [ADDR_W-1:0] r_m_addr;
    logic [1:0]        r_m_size;
    logic [15:0]       r_m_wdata;
    logic              r_m_err;

    rsp_t r_rsp;
    rsp_t w_rsp_nx;

    // Grants are suppressed while in reset so nothing is accepted or issued.
    assign w_en = (r_state == IDLE) && rst_n;

    dmem_rr_arb u_arb (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (req_valid),
        .i_en    (w_en),
        .o_grant (w_grant)
    );

    assign w_accept = |w_grant;
    assign w_sel    = w_grant[1];
    assign w_addr   = req_addr[w_sel];
    assign w_size   = req_size[w_sel];
    assign w_err    = w_addr > LAST_OK;
    assign w_sub    = req_we[w_sel] && ((w_size == SZ_BYTE) || (w_size == SZ_HALF));

    always_comb begin
        w_state_nx = r_state;
        req_ready  = '0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        w_rsp_nx   = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    req_ready = w_grant;
                    mem_addr  = w_addr;
                    if (w_sub) begin
                        w_state_nx = MERGE;
                    end else begin
                        mem_we = req_we[w_sel] && !w_err;
                        if (req_we[w_sel]) begin
                            mem_wdata = req_wdata[w_sel];
                        end
                        w_rsp_nx.pend = 1'b1;
                        w_rsp_nx.port = w_sel;
                        w_rsp_nx.kind = req_we[w_sel] ? RSP_STORE : RSP_LOAD;
                        w_rsp_nx.size = w_size;
                        w_rsp_nx.uns  = req_unsigned[w_sel];
                        w_rsp_nx.err  = w_err;
                    end
                end
            end
            MERGE: begin
                w_state_nx = IDLE;
                mem_addr   = r_m_addr;
                // Reset arriving during the write phase must not corrupt memory.
                mem_we     = rst_n && !r_m_err;
                mem_wdata  = (r_m_size == SZ_BYTE) ? {r_m_wdata[7:0], mem_rdata[23:0]}
                                                   : {r_m_wdata, mem_rdata[15:0]};
                w_rsp_nx.pend = 1'b1;
                w_rsp_nx.port = r_m_port;
                w_rsp_nx.kind = RSP_STORE;
                w_rsp_nx.size = r_m_size;
                w_rsp_nx.err  = r_m_err;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rsp     <= '0;
            r_m_port  <= 1'b0;
            r_m_addr  <= '0;
            r_m_size  <= SZ_BYTE;
            r_m_wdata <= '0;
            r_m_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_rsp   <= w_rsp_nx;
            if ((r_state == IDLE) && w_accept && w_sub) begin
                r_m_port  <= w_sel;
                r_m_addr  <= w_addr;
                r_m_size  <= w_size;
                r_m_wdata <= req_wdata[w_sel][15:0];
                r_m_err   <= w_err;
            end
        end
    end

    assign rsp_valid = r_rsp.pend ? (r_rsp.port ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_err   = r_rsp.pend && r_rsp.err;
    assign rsp_rdata = (r_rsp.pend && (r_rsp.kind == RSP_LOAD) && !r_rsp.err)
                       ? fmt_load(mem_rdata, r_rsp.size, r_rsp.uns) : '0;

endmodule
